// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-addressed MEM-stage data memory with byte lanes and pipelined loads
// Post-reset sweep zeroes the array while the pipeline is held off through stall.
module data_memory_ctrl #(
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 1,
   parameter int INIT_CLEAR = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic        stall
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t        state, state_next;
   logic          run_ready;
   logic [AW-1:0] clr_ptr;
   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic          req_err;
   logic          accept;
   logic [3:0]    be;
   logic [31:0]   wd;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if (INIT_CLEAR != 0) state <= S_INIT;
         else                 state <= S_RUN;
         clr_ptr <= '0;
      end else begin
         state <= state_next;
         if (state == S_INIT) clr_ptr <= clr_ptr + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      run_ready  = 1'b0;
      case (state)
         S_INIT: if (clr_ptr == LAST_WORD) state_next = S_RUN;
         S_RUN:  run_ready = 1'b1;
         default: state_next = S_RUN;
      endcase
   end

   // Ready is forced low while reset is held, even when no sweep is configured.
   assign req_ready = run_ready & reset;
   assign stall     = ~req_ready;
   assign accept    = req_valid & req_ready;

   assign idx  = req_addr[AW+1:2];
   assign lane = req_addr[1:0];

   always_comb begin
      req_err = 1'b0;
      if (req_size == 2'b11)                      req_err = 1'b1;
      if (req_size == 2'b01 && lane[0])           req_err = 1'b1;
      if (req_size == 2'b10 && lane != 2'b00)     req_err = 1'b1;
      if (req_addr[31:AW+2] != '0)                req_err = 1'b1;
   end

   always_comb begin
      be = 4'b0000;
      wd = req_wdata;
      case (req_size)
         2'b00: begin
            be = 4'b0001 << lane;
            wd = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be = lane[1] ? 4'b1100 : 4'b0011;
            wd = {2{req_wdata[15:0]}};
         end
         2'b10: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state == S_INIT) begin
         mem[clr_ptr] <= '0;
      end else if (accept && req_write && !req_err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
         end
      end
   end

   logic        s0_valid, s0_err, s0_write, s0_unsigned;
   logic [1:0]  s0_size, s0_lane;
   logic [31:0] s0_word, s0_data;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Request attributes are captured only on acceptance so outputs hold between responses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s0_valid    <= 1'b0;
         s0_err      <= 1'b0;
         s0_write    <= 1'b0;
         s0_unsigned <= 1'b0;
         s0_size     <= 2'b00;
         s0_lane     <= 2'b00;
         s0_word     <= '0;
      end else begin
         s0_valid <= accept;
         if (accept) begin
            s0_err      <= req_err;
            s0_write    <= req_write;
            s0_unsigned <= req_unsigned;
            s0_size     <= req_size;
            s0_lane     <= lane;
            s0_word     <= mem[idx];
         end
      end
   end

   assign sel_byte = s0_word[8*s0_lane +: 8];
   assign sel_half = s0_lane[1] ? s0_word[31:16] : s0_word[15:0];

   always_comb begin
      s0_data = '0;
      if (!s0_err && !s0_write) begin
         case (s0_size)
            2'b00: s0_data = s0_unsigned ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            2'b01: s0_data = s0_unsigned ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
            2'b10: s0_data = s0_word;
            default: s0_data = '0;
         endcase
      end
   end

   generate
      if (LATENCY == 1) begin : g_direct
         assign resp_valid = s0_valid;
         assign resp_rdata = s0_data;
         assign resp_error = s0_err;
      end else begin : g_pipe
         logic [LATENCY-2:0] pv;
         logic [LATENCY-2:0] pe;
         logic [31:0]        pd [LATENCY-1];

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               pv <= '0;
               pe <= '0;
               for (int i = 0; i < LATENCY - 1; i++) pd[i] <= '0;
            end else begin
               pv[0] <= s0_valid;
               if (s0_valid) begin
                  pd[0] <= s0_data;
                  pe[0] <= s0_err;
               end
               for (int i = 1; i < LATENCY - 1; i++) begin
                  pv[i] <= pv[i-1];
                  if (pv[i-1]) begin
                     pd[i] <= pd[i-1];
                     pe[i] <= pe[i-1];
                  end
               end
            end
         end

         assign resp_valid = pv[LATENCY-2];
         assign resp_rdata = pd[LATENCY-2];
         assign resp_error = pe[LATENCY-2];
      end
   endgenerate
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - scoreboard bench for data_memory_ctrl (DEPTH=16, LATENCY=3)
module tb_data_memory_ctrl;
   localparam int DEPTH = 16;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        stall;

   data_memory_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT), .INIT_CLEAR(1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
      .stall(stall)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] d;
      logic        e;
      int          due;
   } exp_t;
   exp_t q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wdat,
                        input logic [31:0] ed, input logic ee, input bit track);
      check("req_ready_at_issue", 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wdat;
      if (track) q.push_back('{ed, ee, cyc + LAT});
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic sweep_check(input string name);
      int n = 0;
      while (stall && n < 100) begin
         n++;
         @(negedge clk);
      end
      check(name, 32'(n), 32'(DEPTH));
   endtask

   initial begin
      fork
         begin : monitor
            exp_t x;
            forever begin
               @(negedge clk);
               if (resp_valid) begin
                  if (q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected no response", cyc);
                  end else begin
                     x = q.pop_front();
                     check("resp_rdata", resp_rdata, x.d);
                     check("resp_error", 32'(resp_error), 32'(x.e));
                     check("resp_cycle", 32'(cyc), 32'(x.due));
                  end
               end else if (q.size() != 0 && cyc > q[0].due) begin
                  x = q.pop_front();
                  checks++;
                  errors++;
                  $display("FAIL missing_resp: got no resp_valid by cycle %0d expected one at cycle %0d", cyc, x.due);
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_error", 32'(resp_error), 32'd0);
      check("rst_stall", 32'(stall), 32'd1);

      reset = 1'b1;
      sweep_check("init_sweep_len");
      check("ready_after_sweep", 32'(req_ready), 32'd1);

      // wr, size, uns, addr, wdata, exp_data, exp_err, track
      issue(0, 2'b10, 0, 32'h0,  32'h0,        32'h00000000, 0, 1);
      issue(1, 2'b10, 0, 32'h8,  32'hDEADBEEF, 32'h00000000, 0, 1);
      issue(0, 2'b00, 1, 32'h9,  32'h0,        32'h000000BE, 0, 1);
      issue(0, 2'b00, 0, 32'hB,  32'h0,        32'hFFFFFFDE, 0, 1);
      issue(0, 2'b01, 0, 32'hA,  32'h0,        32'hFFFFDEAD, 0, 1);
      issue(0, 2'b01, 1, 32'h8,  32'h0,        32'h0000BEEF, 0, 1);
      issue(0, 2'b00, 0, 32'h8,  32'h0,        32'hFFFFFFEF, 0, 1);
      issue(1, 2'b00, 0, 32'h9,  32'h1234565A, 32'h00000000, 0, 1);
      issue(0, 2'b10, 0, 32'h8,  32'h0,        32'hDEAD5AEF, 0, 1);
      issue(1, 2'b01, 0, 32'h2,  32'hFFFFCAFE, 32'h00000000, 0, 1);
      issue(0, 2'b10, 0, 32'h0,  32'h0,        32'hCAFE0000, 0, 1);
      issue(1, 2'b10, 0, 32'h3C, 32'h0BADF00D, 32'h00000000, 0, 1);
      issue(0, 2'b01, 0, 32'h3,  32'h0,        32'h00000000, 1, 1);
      issue(1, 2'b10, 0, 32'h6,  32'h11111111, 32'h00000000, 1, 1);
      issue(0, 2'b10, 0, 32'h4,  32'h0,        32'h00000000, 0, 1);
      issue(0, 2'b11, 0, 32'h0,  32'h0,        32'h00000000, 1, 1);
      issue(0, 2'b10, 0, 32'h40, 32'h0,        32'h00000000, 1, 1);
      issue(1, 2'b10, 0, 32'h40, 32'h77777777, 32'h00000000, 1, 1);
      issue(0, 2'b10, 0, 32'h80000000, 32'h0,  32'h00000000, 1, 1);
      issue(0, 2'b10, 0, 32'h0,  32'h0,        32'hCAFE0000, 0, 1);
      idle(1);

      issue(0, 2'b10, 0, 32'h0,  32'h0,        32'hCAFE0000, 0, 1);
      issue(0, 2'b10, 0, 32'h4,  32'h0,        32'h00000000, 0, 1);
      issue(0, 2'b10, 0, 32'h8,  32'h0,        32'hDEAD5AEF, 0, 1);
      issue(0, 2'b10, 0, 32'h3C, 32'h0,        32'h0BADF00D, 0, 1);
      idle(8);
      check("drain1", 32'(q.size()), 32'd0);

      issue(0, 2'b10, 0, 32'h0,  32'h0,        32'h0, 0, 0);
      issue(0, 2'b10, 0, 32'h4,  32'h0,        32'h0, 0, 0);
      reset     = 1'b0;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("midtraffic_rst_ready", 32'(req_ready), 32'd0);
      check("midtraffic_rst_valid", 32'(resp_valid), 32'd0);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("midsweep_stall", 32'(stall), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("midsweep_rst_stall", 32'(stall), 32'd1);
      reset = 1'b1;
      sweep_check("sweep_restart_len");

      issue(0, 2'b10, 0, 32'h3C, 32'h0,        32'h00000000, 0, 1);
      issue(0, 2'b10, 0, 32'h8,  32'h0,        32'h00000000, 0, 1);
      idle(8);
      check("drain2", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
